// File: rtl/lfu_pkg.sv
// Shared encodings and sizes for the LFU buffer lookup front-end.
package lfu_pkg;
    localparam int NUM_BUF = 4;
    localparam int BUF_W   = 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CMP   = 3'd1,
        REQ   = 3'd2,
        GRANT = 3'd3,
        FILL  = 3'd4,
        RSP   = 3'd5
    } state_t;
endpackage

// File: rtl/lfu_tag_store.sv
// Four-entry fully associative tag store with combinational compare and free-slot search.
module lfu_tag_store
    import lfu_pkg::*;
#(
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [BUF_W-1:0] widx,
    input  logic [TAG_W-1:0] wtag,
    input  logic             flush,
    input  logic [TAG_W-1:0] tag,
    output logic             hit,
    output logic [BUF_W-1:0] hit_idx,
    output logic             any_free,
    output logic [BUF_W-1:0] free_idx
);
    logic [NUM_BUF-1:0][TAG_W-1:0] tags;
    logic [NUM_BUF-1:0]            vld;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tags <= '0;
            vld  <= '0;
        end else if (flush) begin
            vld <= '0;
        end else if (we) begin
            tags[widx] <= wtag;
            vld[widx]  <= 1'b1;
        end
    end

    // Scan high to low so the lowest matching / free index wins.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        any_free = 1'b0;
        free_idx = '0;
        for (int i = NUM_BUF - 1; i >= 0; i--) begin
            if (vld[i] && tags[i] == tag) begin
                hit     = 1'b1;
                hit_idx = BUF_W'(i);
            end
            if (!vld[i]) begin
                any_free = 1'b1;
                free_idx = BUF_W'(i);
            end
        end
    end
endmodule

// File: rtl/lfu_buf_lookup.sv
// Lookup front-end: resolves a tag to a buffer, allocating a free or LFU-chosen victim on miss.
module lfu_buf_lookup
    import lfu_pkg::*;
#(
    parameter int TAG_W  = 8,
    parameter int FF_DLY = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_vld,
    input  logic [TAG_W-1:0] req_tag,
    output logic             req_rdy,
    input  logic             flush,
    output logic             rsp_vld,
    output logic             rsp_hit,
    output logic [BUF_W-1:0] rsp_buf,
    input  logic             rsp_rdy,
    output logic             ref_vld,
    output logic [BUF_W-1:0] ref_buf_numbr,
    output logic             new_buf_req,
    input  logic [BUF_W-1:0] buf_num_replc
);
    state_t           state;
    logic [TAG_W-1:0] tag_q;
    logic [BUF_W-1:0] fill_idx;
    logic             hit, any_free;
    logic [BUF_W-1:0] hit_idx, free_idx;

    assign req_rdy = (state == IDLE) && !flush;

    lfu_tag_store #(.TAG_W(TAG_W)) u_store (
        .clk      (clk),
        .rst      (rst),
        .we       (state == FILL),
        .widx     (fill_idx),
        .wtag     (tag_q),
        .flush    (flush && state == IDLE),
        .tag      (tag_q),
        .hit      (hit),
        .hit_idx  (hit_idx),
        .any_free (any_free),
        .free_idx (free_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            tag_q         <= '0;
            fill_idx      <= '0;
            rsp_vld       <= 1'b0;
            rsp_hit       <= 1'b0;
            rsp_buf       <= '0;
            ref_vld       <= 1'b0;
            ref_buf_numbr <= '0;
            new_buf_req   <= 1'b0;
        end else begin
            ref_vld     <= 1'b0;
            new_buf_req <= 1'b0;
            case (state)
                IDLE: if (!flush && req_vld) begin
                    tag_q <= req_tag;
                    state <= CMP;
                end
                CMP: if (hit) begin
                    rsp_vld       <= 1'b1;
                    rsp_hit       <= 1'b1;
                    rsp_buf       <= hit_idx;
                    ref_vld       <= 1'b1;
                    ref_buf_numbr <= hit_idx;
                    state         <= RSP;
                end else if (any_free) begin
                    fill_idx <= free_idx;
                    state    <= FILL;
                end else begin
                    new_buf_req <= 1'b1;
                    state       <= REQ;
                end
                REQ:   state <= GRANT;
                // LFU answer is valid the cycle after the request pulse.
                GRANT: begin
                    fill_idx <= buf_num_replc;
                    state    <= FILL;
                end
                FILL: begin
                    rsp_vld       <= 1'b1;
                    rsp_hit       <= 1'b0;
                    rsp_buf       <= fill_idx;
                    ref_vld       <= 1'b1;
                    ref_buf_numbr <= fill_idx;
                    state         <= RSP;
                end
                RSP: if (rsp_rdy) begin
                    rsp_vld <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lfu_buf_lookup.sv
// Randomized bench for lfu_buf_lookup against an array-based tag-store model.
module tb_lfu_buf_lookup;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_vld = 1'b0;
    logic [7:0] req_tag = '0;
    logic       req_rdy;
    logic       flush = 1'b0;
    logic       rsp_vld, rsp_hit;
    logic [1:0] rsp_buf;
    logic       rsp_rdy = 1'b0;
    logic       ref_vld;
    logic [1:0] ref_buf_numbr;
    logic       new_buf_req;
    logic [1:0] buf_num_replc = '0;

    int npass = 0;
    int ntot  = 0;

    logic [7:0] mtag [4];
    logic       mval [4];

    lfu_buf_lookup #(.TAG_W(8), .FF_DLY(1)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_vld       (req_vld),
        .req_tag       (req_tag),
        .req_rdy       (req_rdy),
        .flush         (flush),
        .rsp_vld       (rsp_vld),
        .rsp_hit       (rsp_hit),
        .rsp_buf       (rsp_buf),
        .rsp_rdy       (rsp_rdy),
        .ref_vld       (ref_vld),
        .ref_buf_numbr (ref_buf_numbr),
        .new_buf_req   (new_buf_req),
        .buf_num_replc (buf_num_replc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ntot++;
        if (got === exp) npass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin
            mval[i] = 1'b0;
            mtag[i] = '0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; req_vld = 1'b0; flush = 1'b0; rsp_rdy = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    // One full lookup transaction; stall cycles also probe ignored flush/req while busy.
    task automatic do_req(input logic [7:0] t, input logic [1:0] vic, input int stall);
        int idx, exp_lat, lat, nbr, nbr_at, refs;
        logic exp_hit;
        idx = -1;
        for (int i = 0; i < 4; i++) if (mval[i] && mtag[i] == t && idx < 0) idx = i;
        if (idx >= 0) begin
            exp_hit = 1'b1; exp_lat = 2;
        end else begin
            exp_hit = 1'b0;
            for (int i = 0; i < 4; i++) if (!mval[i] && idx < 0) idx = i;
            if (idx >= 0) exp_lat = 3;
            else begin idx = int'(vic); exp_lat = 5; end
            mtag[idx] = t;
            mval[idx] = 1'b1;
        end

        @(negedge clk);
        buf_num_replc = vic; req_tag = t; req_vld = 1'b1;
        @(posedge clk); #1;
        req_vld = 1'b0;
        chk("req_rdy_busy", 32'(req_rdy), 0);
        lat = 1; nbr = 0; nbr_at = 0; refs = 0;
        while (!rsp_vld && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (new_buf_req) begin nbr++; nbr_at = lat; end
            if (ref_vld) refs++;
        end
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("rsp_hit", 32'(rsp_hit), 32'(exp_hit));
        chk("rsp_buf", 32'(rsp_buf), 32'(idx));
        chk("ref_pulse", 32'(ref_vld), 1);
        chk("ref_count", 32'(refs), 1);
        chk("ref_buf", 32'(ref_buf_numbr), 32'(idx));
        chk("nbr_count", 32'(nbr), (exp_lat == 5) ? 1 : 0);
        if (exp_lat == 5) chk("nbr_cycle", 32'(nbr_at), 2);

        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            flush = 1'b1; req_vld = 1'b1; req_tag = ~t;
            @(posedge clk); #1;
            chk("stall_vld", 32'(rsp_vld), 1);
            chk("stall_buf", 32'(rsp_buf), 32'(idx));
            chk("stall_hit", 32'(rsp_hit), 32'(exp_hit));
            chk("stall_ref", 32'(ref_vld), 0);
            chk("stall_rdy", 32'(req_rdy), 0);
        end
        @(negedge clk);
        flush = 1'b0; req_vld = 1'b0; rsp_rdy = 1'b1;
        @(posedge clk); #1;
        rsp_rdy = 1'b0;
        chk("rsp_done", 32'(rsp_vld), 0);
        chk("idle_rdy", 32'(req_rdy), 1);
        chk("ref_hold", 32'(ref_buf_numbr), 32'(idx));
    endtask

    task automatic do_flush();
        @(negedge clk);
        flush = 1'b1; req_vld = 1'b1; req_tag = 8'hEE;
        #1 chk("flush_rdy", 32'(req_rdy), 0);
        @(posedge clk); #1;
        chk("flush_stay", 32'(rsp_vld), 0);
        @(negedge clk);
        flush = 1'b0; req_vld = 1'b0;
        for (int i = 0; i < 4; i++) mval[i] = 1'b0;
    endtask

    initial begin
        model_clear();
        do_reset();
        #1;
        chk("rst_rdy", 32'(req_rdy), 1);
        chk("rst_rsp_vld", 32'(rsp_vld), 0);
        chk("rst_rsp_hit", 32'(rsp_hit), 0);
        chk("rst_rsp_buf", 32'(rsp_buf), 0);
        chk("rst_ref_vld", 32'(ref_vld), 0);
        chk("rst_ref_buf", 32'(ref_buf_numbr), 0);
        chk("rst_nbr", 32'(new_buf_req), 0);

        do_req(8'hA5, 2'd3, 0);              // cold miss -> buf 0

        do_reset();
        do_req(8'h11, 2'd0, 0);
        do_req(8'h22, 2'd0, 0);
        do_req(8'h33, 2'd0, 0);
        do_req(8'h44, 2'd0, 0);
        do_req(8'h33, 2'd0, 0);              // hit buf 2
        do_req(8'h55, 2'd1, 5);              // victim 1 with backpressure
        do_req(8'h22, 2'd3, 0);              // 22 was evicted
        do_flush();
        do_req(8'h11, 2'd2, 0);              // miss into buf 0

        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 15) == 0) do_flush();
            do_req(8'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
        end

        // Async reset while in REQ
        do_reset();
        for (int i = 0; i < 4; i++) do_req(8'(8'h80 + i), 2'd0, 0);
        @(negedge clk);
        req_tag = 8'hF0; req_vld = 1'b1; buf_num_replc = 2'd2;
        @(posedge clk); #1;
        req_vld = 1'b0;
        @(posedge clk); #1;
        chk("mid_req_nbr", 32'(new_buf_req), 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_nbr", 32'(new_buf_req), 0);
        chk("arst_rsp_vld", 32'(rsp_vld), 0);
        chk("arst_ref_vld", 32'(ref_vld), 0);
        chk("arst_ref_buf", 32'(ref_buf_numbr), 0);
        chk("arst_rsp_buf", 32'(rsp_buf), 0);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        do_req(8'hA5, 2'd3, 0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
